// File: rtl/cv32e40p_hwloop_ctrl.sv
// cv32e40p_hwloop_ctrl: loop-end hit detection, registered branch-back handshake and decrement strobe
module cv32e40p_hwloop_ctrl #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          pc_i,
  input  logic                 pc_valid_i,
  input  logic                 flush_i,
  input  logic [N_REGS*32-1:0] hwlp_start_addr_i,
  input  logic [N_REGS*32-1:0] hwlp_end_addr_i,
  input  logic [N_REGS*32-1:0] hwlp_counter_i,
  input  logic                 jump_ready_i,
  output logic                 jump_valid_o,
  output logic [31:0]          jump_target_o,
  output logic [N_REGS-1:0]    hwlp_dec_cnt_o,
  output logic                 dec_valid_o,
  output logic [N_REGS-1:0]    hwlp_exit_o,
  output logic                 busy_o
);
  typedef enum logic {IDLE, JUMP_PEND} state_e;
  state_e              state_q, state_d;
  logic [31:0]         jump_target_q, jump_target_d;
  logic [N_REGS-1:0]   dec_cnt_q, dec_cnt_d;
  logic                dec_valid_q, dec_valid_d;
  logic [N_REGS-1:0]   exit_q, exit_d;
  logic                hit;
  logic [N_REG_BITS-1:0] hit_idx;
  logic [31:0]         hit_cnt, hit_start;
  // descending scan so the lowest matching index is the last one written
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    hit_cnt = '0;
    hit_start = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (hwlp_end_addr_i[i*32+:32] == pc_i && hwlp_counter_i[i*32+:32] != 32'd0) begin
        hit = 1'b1;
        hit_idx = N_REG_BITS'(i);
        hit_cnt = hwlp_counter_i[i*32+:32];
        hit_start = hwlp_start_addr_i[i*32+:32];
      end
    end
  end
  // while a jump is pending, everything decoded is wrong-path and is ignored
  always_comb begin
    state_d = state_q;
    jump_target_d = jump_target_q;
    dec_cnt_d = '0;
    dec_valid_d = 1'b0;
    exit_d = '0;
    if (state_q == JUMP_PEND) begin
      state_d = (flush_i || jump_ready_i) ? IDLE : JUMP_PEND;
    end else if (pc_valid_i && !flush_i && hit) begin
      dec_cnt_d[hit_idx] = 1'b1;
      dec_valid_d = 1'b1;
      if (hit_cnt > 32'd1) begin
        state_d = JUMP_PEND;
        jump_target_d = hit_start;
      end else begin
        exit_d[hit_idx] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      jump_target_q <= '0;
      dec_cnt_q <= '0;
      dec_valid_q <= 1'b0;
      exit_q <= '0;
    end else begin
      state_q <= state_d;
      jump_target_q <= jump_target_d;
      dec_cnt_q <= dec_cnt_d;
      dec_valid_q <= dec_valid_d;
      exit_q <= exit_d;
    end
  end
  assign jump_valid_o   = (state_q == JUMP_PEND);
  assign busy_o         = jump_valid_o;
  assign jump_target_o  = jump_target_q;
  assign hwlp_dec_cnt_o = dec_cnt_q;
  assign dec_valid_o    = dec_valid_q;
  assign hwlp_exit_o    = exit_q;
endmodule

// File: tb/tb_cv32e40p_hwloop_ctrl.sv
// tb_cv32e40p_hwloop_ctrl: directed plan plus randomized traffic against a behavioural model
module tb_cv32e40p_hwloop_ctrl;
  localparam int N = 2;
  logic clk = 0, rst_n = 0, pc_valid_i = 0, flush_i = 0, jump_ready_i = 0;
  logic [31:0] pc_i = '0;
  logic [31:0] st[N], en[N], cn[N];
  logic [N*32-1:0] start_f, end_f, cnt_f;
  logic jump_valid_o, dec_valid_o, busy_o;
  logic [31:0] jump_target_o;
  logic [N-1:0] hwlp_dec_cnt_o, hwlp_exit_o;
  int pass_cnt = 0, tot = 0;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign start_f[g*32+:32] = st[g];
    assign end_f[g*32+:32]   = en[g];
    assign cnt_f[g*32+:32]   = cn[g];
  end
  cv32e40p_hwloop_ctrl #(.N_REGS(N)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .flush_i(flush_i),
    .hwlp_start_addr_i(start_f), .hwlp_end_addr_i(end_f), .hwlp_counter_i(cnt_f),
    .jump_ready_i(jump_ready_i), .jump_valid_o(jump_valid_o), .jump_target_o(jump_target_o),
    .hwlp_dec_cnt_o(hwlp_dec_cnt_o), .dec_valid_o(dec_valid_o), .hwlp_exit_o(hwlp_exit_o),
    .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask
  bit m_pend, m_dv, m_rst;
  logic [31:0] m_tgt;
  logic [N-1:0] m_dec, m_exit;
  int w;
  // model: a pending redirect swallows all hits; otherwise the lowest active matching loop acts
  always @(posedge clk) begin
    m_dec = '0;
    m_dv = 0;
    m_exit = '0;
    m_rst = !rst_n;
    if (!rst_n) begin
      m_pend = 0;
    end else if (m_pend) begin
      if (flush_i || jump_ready_i) m_pend = 0;
    end else if (pc_valid_i && !flush_i) begin
      w = -1;
      for (int k = N - 1; k >= 0; k--) if (en[k] == pc_i && cn[k] != 0) w = k;
      if (w >= 0) begin
        m_dec[w] = 1'b1;
        m_dv = 1;
        if (cn[w] > 1) begin
          m_pend = 1;
          m_tgt = st[w];
        end else m_exit[w] = 1'b1;
      end
    end
    #1;
    chk("jump_valid", 32'(jump_valid_o), 32'(m_pend));
    chk("busy", 32'(busy_o), 32'(m_pend));
    chk("dec_cnt", 32'(hwlp_dec_cnt_o), 32'(m_dec));
    chk("dec_valid", 32'(dec_valid_o), 32'(m_dv));
    chk("exit", 32'(hwlp_exit_o), 32'(m_exit));
    if (m_pend) chk("target", jump_target_o, m_tgt);
    if (m_rst) chk("rst_target", jump_target_o, 32'h0);
  end
  task automatic cyc(input logic v, input logic [31:0] pc, input logic fl, input logic rdy);
    @(negedge clk);
    pc_valid_i = v;
    pc_i = pc;
    flush_i = fl;
    jump_ready_i = rdy;
    @(posedge clk);
    #2;
  endtask
  function automatic logic [31:0] pick_cnt();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'd2;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    for (int k = 0; k < N; k++) begin st[k] = '0; en[k] = 32'h300; cn[k] = '0; end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("lit_rst_jv", 32'(jump_valid_o), 32'h0);
    chk("lit_rst_tgt", jump_target_o, 32'h0);
    rst_n = 1;
    st[0] = 32'h100; en[0] = 32'h10C; cn[0] = 3;
    cyc(1, 32'h10C, 0, 1);
    chk("lit_l1_jv", 32'(jump_valid_o), 32'h1);
    chk("lit_l1_tgt", jump_target_o, 32'h100);
    chk("lit_l1_dec", 32'(hwlp_dec_cnt_o), 32'h1);
    cyc(0, 0, 0, 1);
    chk("lit_l1_rel", 32'(jump_valid_o), 32'h0);
    cn[0] = 2;
    cyc(1, 32'h10C, 0, 1);
    chk("lit_l2_tgt", jump_target_o, 32'h100);
    cyc(0, 0, 0, 1);
    cn[0] = 1;
    cyc(1, 32'h10C, 0, 1);
    chk("lit_l3_exit", 32'(hwlp_exit_o), 32'h1);
    chk("lit_l3_jv", 32'(jump_valid_o), 32'h0);
    cn[0] = 0;
    cyc(0, 0, 0, 1);
    st[0] = 32'h180; st[1] = 32'h1C0; en[0] = 32'h200; en[1] = 32'h200; cn[0] = 2; cn[1] = 5;
    cyc(1, 32'h200, 0, 0);
    chk("lit_nest_dec", 32'(hwlp_dec_cnt_o), 32'h1);
    chk("lit_nest_tgt", jump_target_o, 32'h180);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'h200, 0, 0);
      chk("lit_bp_jv", 32'(jump_valid_o), 32'h1);
      chk("lit_bp_dec", 32'(dec_valid_o), 32'h0);
    end
    cyc(0, 0, 0, 1);
    chk("lit_bp_rel", 32'(jump_valid_o), 32'h0);
    cyc(1, 32'h200, 0, 0);
    cyc(0, 0, 1, 0);
    chk("lit_fl_jv", 32'(jump_valid_o), 32'h0);
    chk("lit_fl_dec", 32'(dec_valid_o), 32'h0);
    cn[0] = 0; cn[1] = 0;
    cyc(1, 32'h200, 0, 1);
    chk("lit_c0_dv", 32'(dec_valid_o), 32'h0);
    cn[0] = 1;
    cyc(1, 32'h200, 1, 1);
    chk("lit_c1fl_exit", 32'(hwlp_exit_o), 32'h0);
    cn[0] = 2;
    cyc(1, 32'h200, 0, 0);
    rst_n = 0;
    cyc(1, 32'h200, 0, 0);
    chk("lit_r_jv", 32'(jump_valid_o), 32'h0);
    chk("lit_r_dv", 32'(dec_valid_o), 32'h0);
    cyc(1, 32'h200, 0, 0);
    chk("lit_r2_tgt", jump_target_o, 32'h0);
    rst_n = 1;
    cyc(0, 0, 0, 0);
    cyc(1, 32'h200, 0, 1);
    chk("lit_ra_jv", 32'(jump_valid_o), 32'h1);
    chk("lit_ra_dec", 32'(hwlp_dec_cnt_o), 32'h1);
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        st[k] = $urandom;
        en[k] = 32'h200 + 4 * $urandom_range(0, 2);
        cn[k] = pick_cnt();
      end
      rst_n = ($urandom_range(0, 63) != 0);
      cyc($urandom_range(0, 3) != 0, 32'h200 + 4 * $urandom_range(0, 3),
          $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
    end
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule

// File: doc/cv32e40p_hwloop_ctrl.md
# cv32e40p_hwloop_ctrl

Hardware-loop controller: the read side of the hardware-loop register file. Each cycle it compares the accepted instruction PC against the loop end addresses. On a loop-end hit it issues a registered branch-back request to the fetch stage with a valid/ready handshake. It also returns the one-hot decrement strobe and qualifying valid that drive the register file's `hwlp_dec_cnt_i` / `valid_i` inputs.

## Interface
Parameters:
- `N_REGS`, 2: number of hardware loops; index 0 is the innermost loop and has the highest priority.
- `N_REG_BITS`, `$clog2(N_REGS)`: loop index width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `pc_i`  in  32  PC of the instruction in decode.
- `pc_valid_i`  in  1  instruction at `pc_i` is accepted (issued) this cycle.
- `flush_i`  in  1  pipeline flush (exception, interrupt, debug); cancels a pending jump.
- `hwlp_start_addr_i`  in  N_REGS*32  loop start addresses, loop k at `[k*32+:32]`.
- `hwlp_end_addr_i`  in  N_REGS*32  address of the last body instruction of each loop.
- `hwlp_counter_i`  in  N_REGS*32  remaining iteration counts.
- `jump_ready_i`  in  1  fetch accepts the redirect.
- `jump_valid_o`  out  1  redirect request.
- `jump_target_o`  out  32  redirect address; held stable while `jump_valid_o`=1.
- `hwlp_dec_cnt_o`  out  N_REGS  one-hot decrement strobe to the register file.
- `dec_valid_o`  out  1  qualifies `hwlp_dec_cnt_o`; drives the register file's `valid_i`.
- `hwlp_exit_o`  out  N_REGS  one-hot single-cycle pulse marking the final iteration of loop k.
- `busy_o`  out  1  jump pending; decode must not accept further instructions.

## Operation
- Hit on loop k: `pc_valid_i`=1, `pc_i`==end[k], and counter[k]!=0.
- Several loops hit: the lowest k wins, and only that loop is acted on.
- Hit with counter[k]>1: jump to start[k] and decrement loop k.
- Hit with counter[k]==1: no jump; decrement loop k (it reaches 0) and pulse `hwlp_exit_o[k]`.
- counter[k]==0: loop k is inactive and never hits, even if `pc_i` equals end[k].
- Counter compare is a full 32-bit unsigned compare; 0xFFFF_FFFF counts as >1.
- FSM states:
  - IDLE: hits are evaluated.
  - JUMP_PEND: entered from IDLE on a jump hit.
    - Returns to IDLE on a rising edge with `jump_ready_i`=1, or with `flush_i`=1.
    - All hits are ignored in JUMP_PEND, including the handshake cycle, because instructions after end[k] are wrong-path.
- `flush_i` in IDLE suppresses hit evaluation that cycle: no decrement, no jump.
- A decrement already registered is never cancelled by a flush.
- Reset (`rst_n`=0 at a rising edge, any state including mid-handshake):
  - State returns to IDLE.
  - All outputs go to 0: `jump_valid_o`=0, `jump_target_o`=0, `hwlp_dec_cnt_o`=0, `dec_valid_o`=0, `hwlp_exit_o`=0, `busy_o`=0.
  - A pending jump is dropped.

## Timing
- Hit sampled at edge E; at E+1:
  - `hwlp_dec_cnt_o`=onehot(k) and `dec_valid_o`=1, for exactly one cycle.
  - `hwlp_exit_o[k]`=1 for one cycle on the exit case.
  - On the jump case, `jump_valid_o`=1 and `busy_o`=1, with `jump_target_o`=start[k] as captured at E.
- The register file therefore decrements at E+2, and the updated counter is visible from E+2.
- Back-to-back hits on the same loop cannot see a stale counter:
  - A jump hit blocks the next hit through JUMP_PEND.
  - An exit hit moves the PC past end[k].
- `jump_valid_o` stays high, with `jump_target_o` constant, until an edge samples `jump_ready_i`=1; it is low the cycle after.
- `jump_ready_i` already high at E+1 gives a 1-cycle pulse.
- `jump_ready_i` and `flush_i` in the same cycle: the flush wins; the outcome equals the flush case.
- `busy_o` equals `jump_valid_o`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single loop, start=0x100, end=0x10C, cnt=3, `jump_ready_i`=1:
  - Hits at 0x10C yield two redirects to 0x100, each with a dec pulse on bit 0.
  - The third hit gives a dec pulse plus `hwlp_exit_o[0]` and no jump.
- Nested loops, end[0]=end[1]=0x200, cnt0=2, cnt1=5: a hit decrements only loop 0 (`hwlp_dec_cnt_o`=2'b01), target=start[0].
- Handshake backpressure: `jump_ready_i` held low 4 cycles after a hit.
  - `jump_valid_o`/`jump_target_o` stable for 4 cycles.
  - A repeated `pc_i`=end hit during that time produces no second dec.
  - Release at cycle 5 gives `jump_valid_o`=0 at cycle 6.
- Flush mid-pending (`flush_i`=1 while `jump_valid_o`=1): `jump_valid_o`=0 next cycle; the dec pulse already emitted is not repeated.
- Counter=0 with `pc_i`=end[0]: no outputs.
- Counter=1 with `flush_i`=1 in the hit cycle: no dec, no exit pulse.
- Synchronous reset asserted during JUMP_PEND: all outputs 0 after the next edge.
  - Outputs stay 0 while `rst_n`=0.
  - A hit one cycle after release behaves normally.
